// File: rtl/bottle_fill_ctrl.sv
// bottle_fill_ctrl: pill bottling controller with BCD targets/counts, fault recovery, blinking display and buzzer
module bottle_fill_ctrl #(
  parameter int PILL_DIGITS = 3,
  parameter int BOTTLE_DIGITS = 2,
  parameter int BEEP_DIV = 250,
  parameter int BLINK_DIV = 125
) (
  input  logic clk_1khz,
  input  logic switch_clr,
  input  logic btn_sel,
  input  logic btn_inc,
  input  logic btn_go,
  input  logic pill_pulse,
  input  logic estop,
  input  logic hopper_empty,
  input  logic conveyor_stall,
  output logic [1:0] state_o,
  output logic [4*(PILL_DIGITS+BOTTLE_DIGITS)-1:0] disp_bcd,
  output logic [2:0] fault_code,
  output logic feeder_en,
  output logic beep
);
  localparam int P = PILL_DIGITS;
  localparam int D = PILL_DIGITS + BOTTLE_DIGITS;
  localparam int PW = $clog2(D);
  localparam int BLW = $clog2(BLINK_DIV + 1);
  localparam int BPW = $clog2(BEEP_DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(D - 1);
  localparam logic [BLW-1:0] BLK_END = BLW'(BLINK_DIV - 1);
  localparam logic [BPW-1:0] H_DONE = BPW'(BEEP_DIV - 1);
  localparam logic [BPW-1:0] H_ERR = BPW'(BEEP_DIV / 2 - 1);
  localparam logic [4*D-1:0] TGT_RST = (4*D)'(1) | ((4*D)'(1) << (4*P));
  typedef enum logic [1:0] {SETTING, RUNNING, DONE, ERROR} state_t;
  state_t state, st_n;
  logic [D-1:0][3:0] tgt, cnt, disp;
  logic [P-1:0][3:0] pn;
  logic [D-P-1:0][3:0] bn;
  logic [PW-1:0] pos;
  logic [BLW-1:0] blk;
  logic [BPW-1:0] bdiv, half;
  logic p_sel, p_inc, p_go, p_pill, e_sel, e_inc, e_go, e_pill;
  logic fault, pc, bc, hit_p, hit_b, blink_ph;
  assign e_sel = btn_sel & ~p_sel;
  assign e_inc = btn_inc & ~p_inc;
  assign e_go = btn_go & ~p_go;
  assign e_pill = pill_pulse & ~p_pill;
  assign fault = estop | hopper_empty | conveyor_stall;
  assign hit_p = pn == tgt[P-1:0];
  assign hit_b = bn == tgt[D-1:P];
  assign half = state == DONE ? H_DONE : H_ERR;
  // post-increment counts feed both the update and the completion compare
  always_comb begin
    pn = cnt[P-1:0];
    bn = cnt[D-1:P];
    pc = 1'b1;
    bc = 1'b1;
    for (int i = 0; i < P; i++) begin
      pn[i] = pc ? (cnt[i] == 4'd9 ? 4'd0 : cnt[i] + 4'd1) : cnt[i];
      pc = pc & (cnt[i] == 4'd9);
    end
    for (int i = 0; i < D-P; i++) begin
      bn[i] = bc ? (cnt[P+i] == 4'd9 ? 4'd0 : cnt[P+i] + 4'd1) : cnt[P+i];
      bc = bc & (cnt[P+i] == 4'd9);
    end
  end
  assign st_n = state == SETTING ? (e_go && |tgt[P-1:0] && |tgt[D-1:P] ? RUNNING : SETTING)
              : state == RUNNING ? (fault ? ERROR : (e_pill && hit_p && hit_b ? DONE : RUNNING))
              : state == DONE ? (e_go ? SETTING : DONE)
              : (e_go && !fault ? RUNNING : ERROR);
  always_comb begin
    disp = state == SETTING ? tgt : cnt;
    if (state == SETTING && !blink_ph) disp[pos] = 4'hF;
  end
  assign disp_bcd = disp;
  assign state_o = state;
  assign feeder_en = state == RUNNING && !fault;
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state <= SETTING;
      pos <= '0;
      cnt <= '0;
      tgt <= TGT_RST;
      fault_code <= '0;
      {p_sel, p_inc, p_go, p_pill} <= '0;
      blk <= '0;
      blink_ph <= 1'b1;
      bdiv <= '0;
      beep <= 1'b0;
    end else begin
      {p_sel, p_inc, p_go, p_pill} <= {btn_sel, btn_inc, btn_go, pill_pulse};
      state <= st_n;
      blk <= blk == BLK_END ? '0 : blk + 1'b1;
      if (blk == BLK_END) blink_ph <= ~blink_ph;
      if (st_n != state) begin
        bdiv <= '0;
        beep <= 1'b0;
      end else if (state == DONE || state == ERROR) begin
        bdiv <= bdiv == half ? '0 : bdiv + 1'b1;
        if (bdiv == half) beep <= ~beep;
      end
      if (state == SETTING && e_inc) tgt[pos] <= tgt[pos] == 4'd9 ? 4'd0 : tgt[pos] + 4'd1;
      if (state == SETTING && e_sel) pos <= pos == LAST ? '0 : pos + 1'b1;
      if (state == RUNNING && fault) fault_code <= {conveyor_stall, hopper_empty, estop};
      if (state == RUNNING && !fault && e_pill) begin
        cnt[P-1:0] <= hit_p ? '0 : pn;
        if (hit_p) cnt[D-1:P] <= bn;
      end
      if ((state == SETTING && st_n == RUNNING) || (state == DONE && e_go)) cnt <= '0;
    end
  end
endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// tb_bottle_fill_ctrl: directed table, hand sequences and randomized run against a behavioural model
`timescale 1ns/1ps
module tb_bottle_fill_ctrl;
  localparam logic [1:0] SET = 2'd0, RUN = 2'd1, DN = 2'd2, ERR = 2'd3;
  logic clk = 1'b0, rst_n = 1'b1, sel = 1'b0, inc = 1'b0, go = 1'b0, pill = 1'b0;
  logic [2:0] flt = 3'b000;
  logic [1:0] st;
  logic [19:0] disp;
  logic [2:0] fc;
  logic feed, bp;
  int total = 0, bad = 0;
  int m_st, m_pos, m_pc, m_bc, m_fc, m_blk, m_bn;
  int tdig[5];
  bit ps, pi, pg, pp;
  typedef struct {
    bit s, i, g, p;
    logic [2:0] f;
    int n;
    logic [1:0] est;
    logic [19:0] ed;
    int ep;
    logic [2:0] efc;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  bottle_fill_ctrl dut (
    .clk_1khz(clk), .switch_clr(rst_n), .btn_sel(sel), .btn_inc(inc), .btn_go(go),
    .pill_pulse(pill), .estop(flt[0]), .hopper_empty(flt[1]), .conveyor_stall(flt[2]),
    .state_o(st), .disp_bcd(disp), .fault_code(fc), .feeder_en(feed), .beep(bp)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] m_disp();
    logic [19:0] r = '0;
    int d[5];
    if (m_st == 0) begin
      for (int i = 0; i < 5; i++) d[i] = tdig[i];
      if ((m_blk / 125) % 2 == 1) d[m_pos] = 15;
    end else begin
      d[0] = m_pc % 10; d[1] = (m_pc / 10) % 10; d[2] = m_pc / 100;
      d[3] = m_bc % 10; d[4] = m_bc / 10;
    end
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'(d[i]);
    return r;
  endfunction

  function automatic logic [26:0] m_out();
    int b = m_st == 2 ? (m_bn / 250) % 2 : m_st == 3 ? (m_bn / 125) % 2 : 0;
    return {2'(m_st), 3'(m_fc), m_st == 1 && flt == 3'b000, 1'(b), m_disp()};
  endfunction

  task automatic m_reset();
    m_st = 0; m_pos = 0; m_pc = 0; m_bc = 0; m_fc = 0; m_blk = 0; m_bn = 0;
    tdig = '{1, 0, 0, 1, 0};
    ps = 0; pi = 0; pg = 0; pp = 0;
  endtask

  task automatic m_step();
    bit es = sel && !ps, ei = inc && !pi, eg = go && !pg, ep = pill && !pp, f = flt != 3'b000;
    int pt = tdig[0] + 10*tdig[1] + 100*tdig[2], bt = tdig[3] + 10*tdig[4], nst = m_st, p;
    case (m_st)
      0: begin
        if (ei) tdig[m_pos] = (tdig[m_pos] + 1) % 10;
        if (es) m_pos = (m_pos + 1) % 5;
        if (eg && pt != 0 && bt != 0) begin nst = 1; m_pc = 0; m_bc = 0; end
      end
      1: if (f) begin
        nst = 3; m_fc = int'(flt);
      end else if (ep) begin
        p = (m_pc + 1) % 1000;
        if (p == pt) begin
          m_pc = 0; m_bc = (m_bc + 1) % 100;
          if (m_bc == bt) nst = 2;
        end else m_pc = p;
      end
      2: if (eg) begin nst = 0; m_pc = 0; m_bc = 0; end
      default: if (eg && !f) nst = 1;
    endcase
    m_bn = nst == m_st ? m_bn + 1 : 0;
    m_st = nst;
    m_blk++;
    ps = sel; pi = inc; pg = go; pp = pill;
  endtask

  task automatic tick(bit s, bit i, bit g, bit p, logic [2:0] f);
    sel = s; inc = i; go = g; pill = p; flt = f;
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sel = 0; inc = 0; go = 0; pill = 0; flt = 3'b000;
    m_reset();
    #1;
    check("reset", {st, fc, feed, bp, disp}, {SET, 3'b000, 1'b0, 1'b0, 20'h01001});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(bit s, bit i, bit g, bit p, logic [2:0] f, int n, logic [1:0] est,
                     logic [19:0] ed, int ep, logic [2:0] efc);
    vec_t v;
    v.s = s; v.i = i; v.g = g; v.p = p; v.f = f; v.n = n; v.est = est; v.ed = ed; v.ep = ep; v.efc = efc;
    tv.push_back(v);
  endtask

  initial begin
    logic [19:0] m;
    logic [2:0] f;
    logic last;
    int t1, t2;
    add(0,1,0,0,3'b000, 1, SET, 20'h01002, 0, 3'b000);
    add(1,0,0,0,3'b000, 1, SET, 20'h01002, 1, 3'b000);
    add(0,1,0,0,3'b000, 1, SET, 20'h01012, 1, 3'b000);
    add(1,0,0,0,3'b000, 2, SET, 20'h01012, 3, 3'b000);
    add(0,1,0,0,3'b000, 2, SET, 20'h03012, 3, 3'b000);
    add(1,0,0,0,3'b000, 1, SET, 20'h03012, 4, 3'b000);
    add(0,1,0,0,3'b000, 9, SET, 20'h93012, 4, 3'b000);
    add(0,1,0,0,3'b000, 1, SET, 20'h03012, 4, 3'b000);
    add(1,0,0,0,3'b000, 1, SET, 20'h03012, 0, 3'b000);
    add(0,0,1,0,3'b000, 1, RUN, 20'h00000, 0, 3'b000);
    add(0,0,0,1,3'b000, 11, RUN, 20'h00011, 0, 3'b000);
    add(0,0,0,1,3'b000, 1, RUN, 20'h01000, 0, 3'b000);
    add(0,0,0,1,3'b000, 12, RUN, 20'h02000, 0, 3'b000);
    add(0,0,0,1,3'b000, 5, RUN, 20'h02005, 0, 3'b000);
    add(0,0,0,1,3'b010, 1, ERR, 20'h02005, 0, 3'b010);
    add(0,0,1,1,3'b010, 1, ERR, 20'h02005, 0, 3'b010);
    add(0,0,1,0,3'b000, 1, RUN, 20'h02005, 0, 3'b010);
    add(0,0,0,1,3'b000, 7, DN, 20'h03000, 0, 3'b010);
    add(0,0,0,1,3'b001, 1, DN, 20'h03000, 0, 3'b010);
    add(0,0,1,0,3'b000, 1, SET, 20'h03012, 0, 3'b010);
    add(0,1,0,0,3'b000, 8, SET, 20'h03010, 0, 3'b010);
    add(1,0,0,0,3'b000, 1, SET, 20'h03010, 1, 3'b010);
    add(0,1,0,0,3'b000, 9, SET, 20'h03000, 1, 3'b010);
    add(0,0,1,0,3'b111, 1, SET, 20'h03000, 1, 3'b010);
    #2;
    do_reset();
    foreach (tv[k]) begin
      for (int r = 0; r < tv[k].n; r++) begin
        tick(tv[k].s, tv[k].i, tv[k].g, tv[k].p, tv[k].f);
        tick(0, 0, 0, 0, tv[k].f);
      end
      m = tv[k].est == SET ? 20'hF << (4 * tv[k].ep) : 20'h0;
      check($sformatf("row%0d_state", k), st, tv[k].est);
      check($sformatf("row%0d_disp", k), disp | m, tv[k].ed | m);
      check($sformatf("row%0d_fault", k), fc, tv[k].efc);
      check($sformatf("row%0d_feeder", k), feed, tv[k].est == RUN && tv[k].f == 3'b000);
      if (tv[k].est < DN) check($sformatf("row%0d_beep", k), bp, 1'b0);
    end
    do_reset();
    tick(0, 0, 1, 0, 3'b000);
    tick(0, 0, 0, 0, 3'b000);
    tick(0, 0, 0, 1, 3'b000);
    check("single_done_state", st, DN);
    check("single_done_disp", disp, 20'h01000);
    check("single_done_beep", bp, 1'b0);
    last = bp; t1 = -1; t2 = -1;
    for (int c = 1; c <= 600; c++) begin
      tick(0, 0, 0, 0, 3'b000);
      if (bp !== last) begin
        if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
        last = bp;
      end
    end
    check("beep_first_toggle", t1, 250);
    check("beep_second_toggle", t2, 500);
    do_reset();
    for (int e = 0; e < 8; e++) begin
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        f = flt;
        for (int b = 0; b < 3; b++) f[b] = f[b] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) == 0);
        tick($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 1) == 1, f);
        check("model", {st, fc, feed, bp, disp}, m_out());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
